// File: rtl/coherent_avg_pkg.sv
// coherent_avg_pkg
//   Shared types and default widths for the coherent frame averager.
//   state_t : top-level FSM encoding (IDLE, ACCUM, DUMP)
//   DEF_*   : default widths for sample, accumulator and frame address
//   N_W     : width of the processor frame-count register
package coherent_avg_pkg;

    localparam int DEF_DATA_W = 14;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int N_W        = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DUMP
    } state_t;

endpackage

// File: rtl/coherent_avg_ram.sv
// coherent_avg_ram
//   Simple dual-port accumulator RAM, ACC_W x 2**ADDR_W.
//   Contents are not reset: the first frame of every run overwrites them.
//   clk             : clock
//   wr_en/addr/data : write port, takes effect at the clock edge
//   rd_en/rd_addr   : read request
//   rd_data         : registered read data, valid one cycle after rd_en
module coherent_avg_ram #(
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ACC_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ACC_W-1:0]  rd_data
);

    logic [ACC_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/coherent_frame_averager.sv
// coherent_frame_averager
//   Sums n_frames consecutive frames of 2**ADDR_W signed samples point by
//   point, then streams the per-index sums out. Software divides by N.
//   clk, reset_n        : clock, asynchronous active-low reset
//   n_frames            : frame count (0 treated as 1), latched at start
//   start               : one-cycle pulse, begins a run when idle
//   in_valid, in_data   : sample stream, accepted only while accumulating
//   out_valid, out_data : sum for out_index, FRAME_LEN contiguous words
//   out_index           : sample index of out_data
//   busy                : high from start acceptance until the run ends
//   done                : pulses with the last output word
module coherent_frame_averager
    import coherent_avg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_W-1:0]           n_frames,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [ADDR_W-1:0]        out_index,
    output logic                     busy,
    output logic                     done
);

    localparam int FRAME_LEN = 2**ADDR_W;

    state_t              state;
    logic [N_W-1:0]      n_lat;
    logic [N_W-1:0]      frm;
    logic [ADDR_W-1:0]   idx;

    // read-modify-write stage: sample accepted last cycle, written this cycle
    logic                     wr_pend;
    logic                     wr_first;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [DATA_W-1:0] wr_sample;
    logic [ACC_W-1:0]         wr_data;
    logic [ACC_W-1:0]         sample_ext;

    // dump read stage
    logic [ADDR_W:0]     dcnt;      // extra bit marks all reads issued
    logic                dump_arm;  // holds off reads one cycle for the final write
    logic                rd_vld;
    logic [ADDR_W-1:0]   rd_idx;

    logic                accept;
    logic                rd_issue;
    logic                ram_rd_en;
    logic [ADDR_W-1:0]   ram_rd_addr;
    logic [ACC_W-1:0]    ram_q;

    assign accept      = (state == ACCUM) && in_valid;
    assign rd_issue    = (state == DUMP) && dump_arm && !dcnt[ADDR_W];
    assign ram_rd_en   = accept || rd_issue;
    assign ram_rd_addr = accept ? idx : dcnt[ADDR_W-1:0];

    assign sample_ext = {{(ACC_W-DATA_W){wr_sample[DATA_W-1]}}, wr_sample};
    // frame 0 overwrites, so stale RAM from a previous run never leaks in
    assign wr_data    = wr_first ? sample_ext : ram_q + sample_ext;

    coherent_avg_ram #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_pend),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            n_lat     <= '0;
            frm       <= '0;
            idx       <= '0;
            wr_pend   <= 1'b0;
            wr_first  <= 1'b0;
            wr_addr   <= '0;
            wr_sample <= '0;
            dcnt      <= '0;
            dump_arm  <= 1'b0;
            rd_vld    <= 1'b0;
            rd_idx    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            wr_pend <= accept;
            if (accept) begin
                wr_addr   <= idx;
                wr_first  <= (frm == '0);
                wr_sample <= in_data;
            end

            rd_vld <= rd_issue;
            if (rd_issue) rd_idx <= dcnt[ADDR_W-1:0];

            out_valid <= rd_vld;
            done      <= rd_vld && (rd_idx == ADDR_W'(FRAME_LEN - 1));
            if (rd_vld) begin
                out_data  <= ram_q;
                out_index <= rd_idx;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        n_lat <= (n_frames == '0) ? N_W'(1) : n_frames;
                        idx   <= '0;
                        frm   <= '0;
                        busy  <= 1'b1;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        idx <= idx + ADDR_W'(1);  // wraps naturally at FRAME_LEN
                        if (idx == ADDR_W'(FRAME_LEN - 1)) begin
                            frm <= frm + N_W'(1);
                            if (frm == n_lat - N_W'(1)) begin
                                dcnt     <= '0;
                                dump_arm <= 1'b0;
                                state    <= DUMP;
                            end
                        end
                    end
                end
                DUMP: begin
                    dump_arm <= 1'b1;
                    if (rd_issue) dcnt <= dcnt + (ADDR_W+1)'(1);
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
